// File: rtl/bidir_bus_ctrl_pkg.sv
// Shared types and defaults for the bidirectional bus controller.
// Holds the FSM state enum, bus owner encoding and timer helpers.
package bidir_bus_ctrl_pkg;

    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned TA_CYC_DEF = 2;
    localparam int unsigned RD_CYC_DEF = 2;
    localparam int unsigned TMR_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TURN  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_READ  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    typedef enum logic {
        OWN_LOCAL    = 1'b0,
        OWN_EXTERNAL = 1'b1
    } owner_t;

    // Timer reload value for a phase lasting cyc cycles (done fires on the last one).
    function automatic logic [TMR_W-1:0] cyc_to_load(input int unsigned cyc);
        return TMR_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/bidir_bus_timer.sv
// Loadable 4-bit down-counter; done is high while the count sits at zero.
module bidir_bus_timer
    import bidir_bus_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_done_c
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

    assign o_done_c = (r_count == '0);

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Bidirectional bus controller: sequences turnaround, write drive/hold and
// timed read strobes on a shared pad bus, tracking which side owns it.
module bidir_bus_ctrl
    import bidir_bus_ctrl_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned TA_CYC = TA_CYC_DEF,
    parameter int unsigned RD_CYC = RD_CYC_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_wr,
    input  logic [DW-1:0] i_req_data,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_data,
    output logic [DW-1:0] o_io_i,
    output logic          o_io_t,
    input  logic [DW-1:0] i_io_o,
    output logic          o_bus_we,
    output logic          o_bus_re
);

    state_t           r_state;
    state_t           w_state_nxt;
    owner_t           r_owner;
    owner_t           w_owner_nxt;
    logic             r_wr;
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    w_wdata_nxt;
    logic             w_accept;
    logic             w_capture;
    logic             w_drive_nxt;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_done;

    bidir_bus_timer u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done_c   (w_tmr_done)
    );

    // Next-state, owner and timer control.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_accept = 1'b1;
                    if (i_req_wr && (r_owner == OWN_LOCAL)) begin
                        w_state_nxt = ST_DRIVE;
                    end else if (!i_req_wr && (r_owner == OWN_EXTERNAL)) begin
                        w_state_nxt = ST_READ;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = cyc_to_load(RD_CYC);
                    end else begin
                        w_state_nxt = ST_TURN;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = cyc_to_load(TA_CYC);
                    end
                end
            end
            ST_TURN: begin
                if (w_tmr_done) begin
                    if (r_wr) begin
                        w_state_nxt = ST_DRIVE;
                    end else begin
                        w_state_nxt = ST_READ;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = cyc_to_load(RD_CYC);
                    end
                end
            end
            ST_DRIVE: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = OWN_LOCAL;
            end
            ST_READ: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_RESP;
                    w_capture   = 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = OWN_EXTERNAL;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wdata_nxt = w_accept ? i_req_data : r_wdata;
    assign w_drive_nxt = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_HOLD);

    // State, request latch and outputs registered from the next state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_LOCAL;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            o_req_ready <= 1'b1;
            o_io_t      <= 1'b1;
            o_io_i      <= '0;
            o_bus_we    <= 1'b0;
            o_bus_re    <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_wdata     <= w_wdata_nxt;
            if (w_accept) begin
                r_wr <= i_req_wr;
            end
            o_req_ready <= (w_state_nxt == ST_IDLE);
            o_io_t      <= !w_drive_nxt;
            o_io_i      <= w_drive_nxt ? w_wdata_nxt : '0;
            o_bus_we    <= (w_state_nxt == ST_DRIVE);
            o_bus_re    <= (w_state_nxt == ST_READ);
            o_rsp_valid <= (w_state_nxt == ST_RESP);
            if (w_capture) begin
                o_rsp_data <= i_io_o;
            end
        end
    end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl: two instances (default timing and TA=1/RD=3)
// checked every cycle against a per-transaction expected-timeline model.
module tb_bidir_bus_ctrl;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic          t;
        logic [DW-1:0] i;
        logic          we;
        logic          re;
        logic          rv;
        logic          rdy;
        logic          cap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n     [2];
    logic          req_valid [2];
    logic          req_wr    [2];
    logic [DW-1:0] req_data  [2];
    logic          rsp_ready [2];
    logic [DW-1:0] io_o      [2];
    logic          req_ready [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rsp_data  [2];
    logic [DW-1:0] io_i      [2];
    logic          io_t      [2];
    logic          bus_we    [2];
    logic          bus_re    [2];

    always #5 clk = ~clk;

    bidir_bus_ctrl #(.DW(DW), .TA_CYC(2), .RD_CYC(2)) u_dut_def (
        .i_clk(clk), .i_rst_n(rst_n[0]),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_wr(req_wr[0]), .i_req_data(req_data[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_data(rsp_data[0]), .o_io_i(io_i[0]), .o_io_t(io_t[0]),
        .i_io_o(io_o[0]), .o_bus_we(bus_we[0]), .o_bus_re(bus_re[0])
    );

    bidir_bus_ctrl #(.DW(DW), .TA_CYC(1), .RD_CYC(3)) u_dut_alt (
        .i_clk(clk), .i_rst_n(rst_n[1]),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_wr(req_wr[1]), .i_req_data(req_data[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_data(rsp_data[1]), .o_io_i(io_i[1]), .o_io_t(io_t[1]),
        .i_io_o(io_o[1]), .o_bus_we(bus_we[1]), .o_bus_re(bus_re[1])
    );

    // Reference model: a timeline of expected cycles per transaction.
    exp_t          tl [2][0:39];
    int            tl_len  [2];
    int            tl_pos  [2];
    exp_t          cur     [2];
    bit            own_ext [2];
    logic [DW-1:0] exp_rsp [2];
    bit            armed   [2];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;

    function automatic int ta_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int rd_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic exp_t rec(input logic t, input logic [DW-1:0] i, input logic we,
                                 input logic re, input logic rv, input logic rdy,
                                 input logic cap);
        exp_t e;
        e.t = t; e.i = i; e.we = we; e.re = re; e.rv = rv; e.rdy = rdy; e.cap = cap;
        return e;
    endfunction

    function automatic exp_t idle_rec();
        return rec(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic chk_val(input string tag, input int k, input logic [31:0] got,
                           input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", tag, k, cyc, got, exp);
        end
    endtask

    task automatic accept(input int k, input bit wr, input logic [DW-1:0] d);
        int n;
        bit need_turn;
        n = 0;
        need_turn = wr ? own_ext[k] : !own_ext[k];
        if (need_turn) begin
            for (int j = 0; j < ta_of(k); j++) begin
                tl[k][n] = rec(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                n = n + 1;
            end
        end
        if (wr) begin
            tl[k][n]     = rec(1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tl[k][n + 1] = rec(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n = n + 2;
        end else begin
            for (int j = 0; j < rd_of(k); j++) begin
                tl[k][n] = rec(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, (j == rd_of(k) - 1));
                n = n + 1;
            end
            tl[k][n] = rec(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            n = n + 1;
        end
        tl_len[k] = n;
        cur[k]    = tl[k][0];
        tl_pos[k] = 1;
    endtask

    task automatic model_edge(input int k);
        if (!rst_n[k]) begin
            cur[k] = idle_rec(); own_ext[k] = 1'b0; exp_rsp[k] = '0;
            tl_len[k] = 0; tl_pos[k] = 0; armed[k] = 1'b1;
            return;
        end
        if (!armed[k]) return;
        if (cur[k].cap) exp_rsp[k] = io_o[k];
        if (cur[k].rdy) begin
            if (req_valid[k]) accept(k, req_wr[k], req_data[k]);
        end else if (cur[k].rv) begin
            if (rsp_ready[k]) begin
                own_ext[k] = 1'b1;
                cur[k] = idle_rec();
            end
        end else if (tl_pos[k] < tl_len[k]) begin
            cur[k] = tl[k][tl_pos[k]];
            tl_pos[k] = tl_pos[k] + 1;
        end else begin
            own_ext[k] = 1'b0;
            cur[k] = idle_rec();
        end
    endtask

    task automatic check_outputs(input int k);
        if (!armed[k]) return;
        chk_val("req_ready", k, 32'(req_ready[k]), 32'(cur[k].rdy));
        chk_val("io_t",      k, 32'(io_t[k]),      32'(cur[k].t));
        chk_val("io_i",      k, 32'(io_i[k]),      32'(cur[k].i));
        chk_val("bus_we",    k, 32'(bus_we[k]),    32'(cur[k].we));
        chk_val("bus_re",    k, 32'(bus_re[k]),    32'(cur[k].re));
        chk_val("rsp_valid", k, 32'(rsp_valid[k]), 32'(cur[k].rv));
        chk_val("rsp_data",  k, 32'(rsp_data[k]),  32'(exp_rsp[k]));
        chk_val("drive_during_re", k, 32'(!io_t[k] && bus_re[k]), 32'(0));
    endtask

    // Called at a negedge: check current outputs, advance model on the
    // inputs now applied, then move to the next negedge.
    task automatic step();
        cyc++;
        for (int k = 0; k < 2; k++) check_outputs(k);
        for (int k = 0; k < 2; k++) model_edge(k);
        @(negedge clk);
    endtask

    function automatic bit flag(input int k, input int sel);
        case (sel)
            0: return cur[k].rdy;
            1: return cur[k].we;
            2: return cur[k].re;
            default: return cur[k].rv;
        endcase
    endfunction

    task automatic wait_for(input int k, input int sel, input string tag);
        for (int n = 0; n < 50; n++) begin
            if (flag(k, sel)) break;
            step();
        end
        chk_val(tag, k, 32'(flag(k, sel)), 32'(1));
    endtask

    task automatic do_req(input int k, input bit wr, input logic [DW-1:0] d);
        wait_for(k, 0, "wait_ready");
        req_valid[k] = 1'b1; req_wr[k] = wr; req_data[k] = d;
        step();
        req_valid[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_wr[k] = 1'b0;
            req_data[k] = '0; rsp_ready[k] = 1'b1; io_o[k] = '0;
            armed[k] = 1'b0; cur[k] = idle_rec(); own_ext[k] = 1'b0;
            exp_rsp[k] = '0; tl_len[k] = 0; tl_pos[k] = 0;
        end
        @(negedge clk);
        step();
        step();
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Directed scenarios on the default instance.
        step();
        do_req(0, 1'b1, 8'hA5);
        do_req(0, 1'b1, 8'h3C);
        io_o[0] = 8'h5A;
        do_req(0, 1'b0, 8'h00);
        wait_for(0, 0, "wait_ready");

        rsp_ready[0] = 1'b0;
        io_o[0] = 8'hC3;
        do_req(0, 1'b0, 8'h00);
        wait_for(0, 3, "wait_rsp");
        req_valid[0] = 1'b1; req_wr[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            io_o[0] = DW'($urandom);
            step();
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        do_req(0, 1'b0, 8'h00);
        wait_for(0, 0, "wait_ready");

        do_req(0, 1'b1, 8'hFF);

        do_req(0, 1'b1, 8'h11);
        wait_for(0, 1, "wait_drive");
        rst_n[0] = 1'b0; step(); rst_n[0] = 1'b1;
        do_req(0, 1'b1, 8'h22);

        do_req(0, 1'b0, 8'h00);
        wait_for(0, 2, "wait_read");
        rst_n[0] = 1'b0; step(); rst_n[0] = 1'b1;
        do_req(0, 1'b1, 8'h33);
        wait_for(0, 0, "wait_ready");

        // Alternate instance: write then read with a changing bus.
        do_req(1, 1'b1, 8'h5C);
        req_valid[1] = 1'b1; req_wr[1] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            io_o[1] = DW'(8'h40 + n);
            step();
            req_valid[1] = 1'b0;
        end

        // Randomized traffic on both instances.
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 2; k++) begin
                req_valid[k] = ($urandom_range(2) == 0);
                req_wr[k]    = 1'($urandom);
                req_data[k]  = DW'($urandom);
                rsp_ready[k] = ($urandom_range(2) != 0);
                io_o[k]      = DW'($urandom);
                rst_n[k]     = ($urandom_range(59) != 0);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b1; req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
        end
        for (int n = 0; n < 10; n++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
